lc3_control_unit: RTL

- Instruction sequence/decode FSM for the SLC-3; sits directly upstream of the datapath and drives all of its load, gate, mux and memory-control inputs.
- Consumes IR opcode bits and BEN fed back from the datapath; steps fetch, decode and execute one instruction at a time.
- Inserts configurable memory wait states and implements the PAUSE handshake with Run/Continue.

---
 rtl/lc3_control_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_control_unit.sv
// SLC-3 fetch/decode/execute sequencer: Moore outputs drive every datapath load, gate, mux and memory strobe.
// Define LC3_PAUSE_IR_EN to pause after each fetch so the new IR is shown on the LEDs.
module lc3_control_unit #(
   parameter int MEM_WAIT = 2
) (
   input  logic       Clk_i,
   input  logic       Reset_i,
   input  logic       Run_i,
   input  logic       Continue_i,
   input  logic [3:0] Opcode_i,
   input  logic       IR_5_i,
   input  logic       IR_11_i,
   input  logic       BEN_i,
   output logic       LD_MAR_o,
   output logic       LD_MDR_o,
   output logic       LD_IR_o,
   output logic       LD_BEN_o,
   output logic       LD_CC_o,
   output logic       LD_REG_o,
   output logic       LD_PC_o,
   output logic       LD_LED_o,
   output logic       GatePC_o,
   output logic       GateMDR_o,
   output logic       GateALU_o,
   output logic       GateMARMUX_o,
   output logic [1:0] PCMUX_o,
   output logic       DRMUX_o,
   output logic       SR1MUX_o,
   output logic       SR2MUX_o,
   output logic       ADDR1MUX_o,
   output logic [1:0] ADDR2MUX_o,
   output logic [1:0] ALUK_o,
   output logic       MIO_EN_o,
   output logic       Mem_OE_o,
   output logic       Mem_WE_o
);

   localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   typedef enum logic [4:0] {
      HALTED, S18, S33, S35, S32, S01, S05, S09, S06, S07, S25, S27,
      S23, S16, S04, S21, S12, S00, S22, PAUSE1, PAUSE2
`ifdef LC3_PAUSE_IR_EN
      , PAUSE_IR1, PAUSE_IR2
`endif
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           cnt_run;
   logic           cnt_last;
   logic           ir11_unused;

   // IR[11] is reserved for JSRR and does not affect sequencing.
   assign ir11_unused = IR_11_i;
   assign cnt_last    = (cnt_q == CW'(MEM_WAIT - 1));

   always_ff @(posedge Clk_i or negedge Reset_i) begin
      if (!Reset_i) begin
         state_q <= HALTED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_run      = 1'b0;
      LD_MAR_o     = 1'b0;
      LD_MDR_o     = 1'b0;
      LD_IR_o      = 1'b0;
      LD_BEN_o     = 1'b0;
      LD_CC_o      = 1'b0;
      LD_REG_o     = 1'b0;
      LD_PC_o      = 1'b0;
      LD_LED_o     = 1'b0;
      GatePC_o     = 1'b0;
      GateMDR_o    = 1'b0;
      GateALU_o    = 1'b0;
      GateMARMUX_o = 1'b0;
      PCMUX_o      = 2'd0;
      DRMUX_o      = 1'b0;
      SR1MUX_o     = 1'b0;
      SR2MUX_o     = 1'b0;
      ADDR1MUX_o   = 1'b0;
      ADDR2MUX_o   = 2'd0;
      ALUK_o       = 2'd0;
      MIO_EN_o     = 1'b0;
      Mem_OE_o     = 1'b1;
      Mem_WE_o     = 1'b1;

      case (state_q)
         HALTED: if (Run_i) state_d = S18;
         S18: begin
            GatePC_o = 1'b1;
            LD_MAR_o = 1'b1;
            LD_PC_o  = 1'b1;
            state_d  = S33;
         end
         S33, S25: begin
            Mem_OE_o = 1'b0;
            MIO_EN_o = 1'b1;
            cnt_run  = 1'b1;
            LD_MDR_o = cnt_last;
            if (cnt_last) state_d = (state_q == S33) ? S35 : S27;
         end
         S35: begin
            GateMDR_o = 1'b1;
            LD_IR_o   = 1'b1;
`ifdef LC3_PAUSE_IR_EN
            state_d   = PAUSE_IR1;
`else
            state_d   = S32;
`endif
         end
`ifdef LC3_PAUSE_IR_EN
         PAUSE_IR1: begin
            LD_LED_o = 1'b1;
            if (Continue_i) state_d = PAUSE_IR2;
         end
         PAUSE_IR2: begin
            LD_LED_o = 1'b1;
            if (!Continue_i) state_d = S32;
         end
`endif
         S32: begin
            LD_BEN_o = 1'b1;
            case (Opcode_i)
               4'b0001: state_d = S01;
               4'b0101: state_d = S05;
               4'b1001: state_d = S09;
               4'b0110: state_d = S06;
               4'b0111: state_d = S07;
               4'b0100: state_d = S04;
               4'b1100: state_d = S12;
               4'b0000: state_d = S00;
               4'b1101: state_d = PAUSE1;
               default: state_d = S18;
            endcase
         end
         S01, S05: begin
            SR1MUX_o  = 1'b1;
            SR2MUX_o  = IR_5_i;
            ALUK_o    = (state_q == S05) ? 2'd1 : 2'd0;
            GateALU_o = 1'b1;
            LD_REG_o  = 1'b1;
            LD_CC_o   = 1'b1;
            state_d   = S18;
         end
         S09: begin
            SR1MUX_o  = 1'b1;
            ALUK_o    = 2'd2;
            GateALU_o = 1'b1;
            LD_REG_o  = 1'b1;
            LD_CC_o   = 1'b1;
            state_d   = S18;
         end
         S06, S07: begin
            ADDR1MUX_o   = 1'b1;
            SR1MUX_o     = 1'b1;
            ADDR2MUX_o   = 2'd1;
            GateMARMUX_o = 1'b1;
            LD_MAR_o     = 1'b1;
            state_d      = (state_q == S06) ? S25 : S23;
         end
         S27: begin
            GateMDR_o = 1'b1;
            LD_REG_o  = 1'b1;
            LD_CC_o   = 1'b1;
            state_d   = S18;
         end
         S23: begin
            ALUK_o    = 2'd3;
            GateALU_o = 1'b1;
            LD_MDR_o  = 1'b1;
            state_d   = S16;
         end
         S16: begin
            Mem_WE_o = 1'b0;
            cnt_run  = 1'b1;
            if (cnt_last) state_d = S18;
         end
         S04: begin
            GatePC_o = 1'b1;
            DRMUX_o  = 1'b1;
            LD_REG_o = 1'b1;
            state_d  = S21;
         end
         S21: begin
            ADDR2MUX_o = 2'd3;
            PCMUX_o    = 2'd2;
            LD_PC_o    = 1'b1;
            state_d    = S18;
         end
         S12: begin
            SR1MUX_o   = 1'b1;
            ADDR1MUX_o = 1'b1;
            PCMUX_o    = 2'd2;
            LD_PC_o    = 1'b1;
            state_d    = S18;
         end
         S00: state_d = BEN_i ? S22 : S18;
         S22: begin
            ADDR2MUX_o = 2'd2;
            PCMUX_o    = 2'd2;
            LD_PC_o    = 1'b1;
            state_d    = S18;
         end
         // Two-phase handshake: a held Continue can only advance one step.
         PAUSE1: begin
            LD_LED_o = 1'b1;
            if (Continue_i) state_d = PAUSE2;
         end
         PAUSE2: begin
            LD_LED_o = 1'b1;
            if (!Continue_i) state_d = S18;
         end
         default: state_d = HALTED;
      endcase

      cnt_d = '0;
      if (cnt_run && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
   end

endmodule
